// File: rtl/maze_move_ctrl.sv
// Player movement sequencer for the 20x20 maze: button -> wall-map check -> commit -> cooldown.
// Define MOVE_WRAP_EN to wrap off-grid moves to the opposite edge instead of bumping.
module maze_move_ctrl #(
  parameter int ROW_W     = 5,
  parameter int COL_W     = 5,
  parameter int MAX_ROW   = 19,
  parameter int MAX_COL   = 19,
  parameter int START_ROW = 1,
  parameter int START_COL = 1,
  parameter int HOLD_CYC  = 2500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic [1:0]       level_select,
  output logic             map_req,
  output logic [ROW_W-1:0] map_row,
  output logic [COL_W-1:0] map_col,
  input  logic             map_valid,
  input  logic             map_wall,
  output logic [ROW_W-1:0] player_row,
  output logic [COL_W-1:0] player_col,
  output logic             busy,
  output logic             bump
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COMMIT, S_COOL} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               map_req_nx, bump_nx;
  logic [ROW_W-1:0]   map_row_nx, player_row_nx, tgt_row;
  logic [COL_W-1:0]   map_col_nx, player_col_nx, tgt_col;
  logic [1:0]         level_q, level_nx;
  logic               any_btn, edge_hit;

  assign any_btn = btn_up | btn_down | btn_left | btn_right;
  assign busy    = (state != S_IDLE);

  // Target cell with fixed priority up > down > left > right.
  always_comb begin
    tgt_row  = player_row;
    tgt_col  = player_col;
    edge_hit = 1'b0;
    if (btn_up) begin
      if (player_row == '0) begin
`ifdef MOVE_WRAP_EN
        tgt_row = ROW_W'(MAX_ROW);
`else
        edge_hit = 1'b1;
`endif
      end else begin
        tgt_row = player_row - ROW_W'(1);
      end
    end else if (btn_down) begin
      if (player_row >= ROW_W'(MAX_ROW)) begin
`ifdef MOVE_WRAP_EN
        tgt_row = '0;
`else
        edge_hit = 1'b1;
`endif
      end else begin
        tgt_row = player_row + ROW_W'(1);
      end
    end else if (btn_left) begin
      if (player_col == '0) begin
`ifdef MOVE_WRAP_EN
        tgt_col = COL_W'(MAX_COL);
`else
        edge_hit = 1'b1;
`endif
      end else begin
        tgt_col = player_col - COL_W'(1);
      end
    end else if (btn_right) begin
      if (player_col >= COL_W'(MAX_COL)) begin
`ifdef MOVE_WRAP_EN
        tgt_col = '0;
`else
        edge_hit = 1'b1;
`endif
      end else begin
        tgt_col = player_col + COL_W'(1);
      end
    end
  end

  // Handshake: map_req is held with map_row/map_col stable until the first
  // cycle map_valid=1; map_wall is sampled in that cycle only.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    map_req_nx    = map_req;
    map_row_nx    = map_row;
    map_col_nx    = map_col;
    player_row_nx = player_row;
    player_col_nx = player_col;
    bump_nx       = 1'b0;
    level_nx      = level_q;
    if (level_select != level_q) begin
      // Level change overrides everything, including an in-flight read.
      state_nx      = S_IDLE;
      cnt_nx        = '0;
      map_req_nx    = 1'b0;
      player_row_nx = ROW_W'(START_ROW);
      player_col_nx = COL_W'(START_COL);
      level_nx      = level_select;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_btn) begin
            if (edge_hit) begin
              bump_nx  = 1'b1;
              cnt_nx   = '0;
              state_nx = S_COOL;
            end else begin
              map_row_nx = tgt_row;
              map_col_nx = tgt_col;
              map_req_nx = 1'b1;
              state_nx   = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (map_valid) begin
            map_req_nx = 1'b0;
            if (map_wall) begin
              bump_nx  = 1'b1;
              cnt_nx   = '0;
              state_nx = S_COOL;
            end else begin
              state_nx = S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          player_row_nx = map_row;
          player_col_nx = map_col;
          cnt_nx        = '0;
          state_nx      = S_COOL;
        end
        S_COOL: begin
          if (cnt == CNT_W'(HOLD_CYC - 1)) begin
            cnt_nx   = '0;
            state_nx = S_IDLE;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      map_req    <= 1'b0;
      map_row    <= '0;
      map_col    <= '0;
      player_row <= ROW_W'(START_ROW);
      player_col <= COL_W'(START_COL);
      bump       <= 1'b0;
      level_q    <= level_select;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      map_req    <= map_req_nx;
      map_row    <= map_row_nx;
      map_col    <= map_col_nx;
      player_row <= player_row_nx;
      player_col <= player_col_nx;
      bump       <= bump_nx;
      level_q    <= level_nx;
    end
  end

endmodule
